// File: rtl/axi_ram.sv
// AXI4 slave RAM: independent write (AW/W/B) and read (AR/R) burst engines over a
// single word-wide byte-enabled array. Upper address bits alias modulo 2**MEM_ADDR_WIDTH.
module axi_ram #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int WORD_AW    = MEM_ADDR_WIDTH - ADDR_LSB;
  localparam int DEPTH      = 2 ** WORD_AW;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_BURST = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // FIXED holds, WRAP folds inside a (len+1)*2**size aligned window, everything else increments.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [1:0]            burst,
    input logic [7:0]            len
  );
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] res;
    incr = ONE_A << size;
    mask = ((ADDR_WIDTH'(len) + ONE_A) << size) - ONE_A;
    sum  = addr + incr;
    case (burst)
      2'b00:   res = addr;
      2'b10:   res = (addr & ~mask) | (sum & mask);
      default: res = sum;
    endcase
    return res;
  endfunction

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] r_next_s;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic unused_s;

  assign aw_hs_s  = s_axi_awvalid & awready_q;
  assign w_hs_s   = s_axi_wvalid & wready_q;
  assign b_hs_s   = s_axi_bready & bvalid_q;
  assign ar_hs_s  = s_axi_arvalid & arready_q;
  assign r_hs_s   = s_axi_rready & rvalid_q;
  assign r_next_s = next_addr(r_addr_q, r_size_q, r_burst_q, r_len_q);
  assign unused_s = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                      s_axi_arlock, s_axi_arcache, s_axi_arprot};

  // Write engine next state: the beat count, not wlast, ends the burst.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          w_id_d    = s_axi_awid;
          w_addr_d  = s_axi_awaddr;
          w_len_d   = s_axi_awlen;
          w_size_d  = s_axi_awsize;
          w_burst_d = s_axi_awburst;
          w_cnt_d   = 8'd0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_BURST;
        end else begin
          awready_d = 1'b1;
        end
      end
      W_BURST: begin
        if (w_hs_s) begin
          w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q, w_len_q);
          w_cnt_d  = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            w_state_d = W_RESP;
          end else begin
            wready_d = 1'b1;
          end
        end else begin
          wready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write engine registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_size_q  <= 3'd0;
      w_burst_q <= 2'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
    end
  end

  // Storage is deliberately outside reset so preloaded contents survive it.
  always_ff @(posedge clk) begin
    if (w_hs_s) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) begin
          mem[w_addr_q[MEM_ADDR_WIDTH-1:ADDR_LSB]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read engine next state: data is fetched when a beat is launched, so a
  // same-edge write to that word is not seen and stalled beats stay stable.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_addr_d  = s_axi_araddr;
          r_len_d   = s_axi_arlen;
          r_size_d  = s_axi_arsize;
          r_burst_d = s_axi_arburst;
          r_cnt_d   = 8'd0;
          rid_d     = s_axi_arid;
          rdata_d   = mem[s_axi_araddr[MEM_ADDR_WIDTH-1:ADDR_LSB]];
          rlast_d   = (s_axi_arlen == 8'd0);
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_BURST;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_BURST: begin
        if (r_hs_s) begin
          if (r_cnt_q == r_len_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = r_next_s;
            r_cnt_d  = r_cnt_q + 8'd1;
            rdata_d  = mem[r_next_s[MEM_ADDR_WIDTH-1:ADDR_LSB]];
            rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        arready_d = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read engine registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= 8'd0;
      r_cnt_q   <= 8'd0;
      r_size_q  <= 3'd0;
      r_burst_q <= 2'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_axi_ram.sv
// Randomised + directed bench for axi_ram; a byte-level word array model predicts
// every read beat, with burst addresses computed from the AXI burst rules.
module tb_axi_ram;
  localparam int DW = 64, AW = 64, IW = 4, MAW = 18;

  logic clk, rst_n;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] awcache, arcache;
  logic awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;

  axi_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
    .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(arlock),
    .s_axi_arcache(arcache), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] ref_mem [0:32767];
  logic [63:0] wbuf_d [0:255];
  logic [7:0]  wbuf_s [0:255];
  logic [63:0] rd_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte address of beat i, straight from the AXI burst definitions.
  function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [7:0] len,
                                            input int i);
    logic [63:0] inc, win, base;
    inc = 64'd1 << size;
    if (burst == 2'b00) return a;
    if (burst == 2'b10) begin
      win  = (64'(len) + 64'd1) * inc;
      base = a - (a % win);
      return base + (((a - base) + 64'(i) * inc) % win);
    end
    return a + 64'(i) * inc;
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a >> 3) & 64'h7FFF);
  endfunction

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_awready"}, 64'(awready), 64'd0);
    chk({tag, "_wready"},  64'(wready),  64'd0);
    chk({tag, "_arready"}, 64'(arready), 64'd0);
    chk({tag, "_bvalid"},  64'(bvalid),  64'd0);
    chk({tag, "_rvalid"},  64'(rvalid),  64'd0);
    chk({tag, "_rlast"},   64'(rlast),   64'd0);
    chk({tag, "_ids"},     64'({bid, rid}), 64'd0);
    chk({tag, "_resps"},   64'({bresp, rresp}), 64'd0);
    chk({tag, "_rdata"},   rdata, 64'd0);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst;
    awlock = 1'($urandom); awcache = 4'($urandom); awprot = 3'($urandom);
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_ready_wait", 64'(awready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic finish_b(input logic [3:0] id);
    int n, d;
    d = int'($urandom_range(0, 2));
    n = 0;
    while (!(bvalid && n >= d) && n < 50) begin @(negedge clk); n++; end
    chk("b_valid", 64'(bvalid), 64'd1);
    chk("b_id", 64'(bid), 64'(id));
    chk("b_resp", 64'(bresp), 64'd0);
    chk("w_ready_after", 64'(wready), 64'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_single", 64'(bvalid), 64'd0);
  endtask

  task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    for (int b = 0; b < 8; b++) if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit gaps);
    int beat, n;
    send_aw(id, a, len, size, burst);
    beat = 0; n = 0;
    while (beat <= int'(len) && n < 3000) begin
      wdata  = wbuf_d[beat];
      wstrb  = wbuf_s[beat];
      wlast  = (beat == int'(len));
      wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (wvalid && wready) begin
        model_write(beat_addr(a, size, burst, len, beat), wbuf_d[beat], wbuf_s[beat]);
        beat++;
      end
      @(negedge clk);
      n++;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("w_beats", 64'(beat), 64'(len) + 64'd1);
    finish_b(id);
  endtask

  // rmode: 0 = rready held high, 1 = random, 2 = alternating.
  task automatic axi_read(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int rmode);
    int beat, n;
    rd_q.delete();
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst;
    arlock = 1'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_ready_wait", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    beat = 0; n = 0;
    while (beat <= int'(len) && n < 3000) begin
      chk("r_valid", 64'(rvalid), 64'd1);
      chk("r_data", rdata, ref_mem[widx(beat_addr(a, size, burst, len, beat))]);
      chk("r_id", 64'(rid), 64'(id));
      chk("r_resp", 64'(rresp), 64'd0);
      chk("r_last", 64'(rlast), 64'(beat == int'(len)));
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom);
        default: rready = 1'(n & 1);
      endcase
      if (rready) begin rd_q.push_back(rdata); beat++; end
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    chk("r_done", 64'(rvalid), 64'd0);
  endtask

  initial begin
    logic [63:0] old_w, hi;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] a;
    rst_n = 1'b0;
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready} = '0;
    #1;
    reset_outputs_zero("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Initialise words 0..63 so every later read has a known value.
    for (int i = 0; i < 64; i++) begin wbuf_d[i] = {$urandom, $urandom}; wbuf_s[i] = 8'hFF; end
    axi_write(4'h1, 64'h0, 8'd63, 3'd3, 2'b01, 1'b1);

    // Single-word preload and read.
    wbuf_d[0] = 64'h0000001300000093; wbuf_s[0] = 8'hFF;
    axi_write(4'h2, 64'h1000, 8'd0, 3'd3, 2'b01, 1'b0);
    axi_read(4'h5, 64'h1000, 8'd0, 3'd3, 2'b01, 0);
    chk("single_word", rd_q[0], 64'h0000001300000093);

    // Four-beat INCR write and read-back.
    wbuf_d[0] = 64'h1111111111111111; wbuf_d[1] = 64'h2222222222222222;
    wbuf_d[2] = 64'h3333333333333333; wbuf_d[3] = 64'h4444444444444444;
    for (int i = 0; i < 4; i++) wbuf_s[i] = 8'hFF;
    axi_write(4'h7, 64'h1000, 8'd3, 3'd3, 2'b01, 1'b0);
    axi_read(4'h3, 64'h1000, 8'd3, 3'd3, 2'b01, 0);
    chk("incr4_beats", 64'(rd_q.size()), 64'd4);
    chk("incr4_b3", rd_q[3], 64'h4444444444444444);

    // Partial strobe over an all-ones word.
    wbuf_d[0] = 64'hFFFFFFFFFFFFFFFF; wbuf_s[0] = 8'hFF;
    axi_write(4'h4, 64'h2000, 8'd0, 3'd3, 2'b01, 1'b0);
    wbuf_d[0] = 64'hAAAAAAAABBBBBBBB; wbuf_s[0] = 8'h0F;
    axi_write(4'h4, 64'h2000, 8'd0, 3'd3, 2'b01, 1'b0);
    axi_read(4'h4, 64'h2000, 8'd0, 3'd3, 2'b01, 0);
    chk("strb_merge", rd_q[0], 64'hFFFFFFFFBBBBBBBB);

    // WRAP read starting mid-window, then stalled reads.
    axi_read(4'h9, 64'h18, 8'd3, 3'd3, 2'b10, 0);
    chk("wrap_b1", rd_q[1], ref_mem[0]);
    axi_read(4'hA, 64'h40, 8'd3, 3'd3, 2'b01, 2);
    axi_read(4'hB, 64'h80, 8'd3, 3'd3, 2'b01, 1);

    // Address aliasing above MEM_ADDR_WIDTH.
    axi_read(4'hC, 64'h41000, 8'd0, 3'd3, 2'b01, 0);
    chk("alias", rd_q[0], 64'h1111111111111111);

    // Same-edge write and read launch on word 5: read sees the old value.
    old_w = ref_mem[5];
    send_aw(4'h6, 64'h28, 8'd0, 3'd3, 2'b01);
    chk("same_arready", 64'(arready), 64'd1);
    wdata = 64'hDEADBEEFCAFEF00D; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'h6; araddr = 64'h28; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    chk("same_rvalid", 64'(rvalid), 64'd1);
    chk("same_old", rdata, old_w);
    model_write(64'h28, 64'hDEADBEEFCAFEF00D, 8'hFF);
    rready = 1'b1;
    finish_b(4'h6);
    rready = 1'b0;
    chk("same_rdone", 64'(rvalid), 64'd0);
    axi_read(4'h6, 64'h28, 8'd0, 3'd3, 2'b01, 0);
    chk("same_new", rd_q[0], 64'hDEADBEEFCAFEF00D);

    // Randomised mixed bursts, some with high address bits set.
    for (int t = 0; t < 40; t++) begin
      burst = 2'($urandom_range(0, 3));
      size  = 3'($urandom_range(0, 3));
      hi    = ($urandom_range(0, 1) != 0) ? ({$urandom, $urandom} & ~64'h3FFFF) : 64'd0;
      if (burst == 2'b10) begin
        len = 8'((1 << $urandom_range(1, 3)) - 1);
        a   = 64'($urandom_range(0, 40)) * 64'd8 + ((64'($urandom_range(0, 7)) >> size) << size);
      end else begin
        len = 8'($urandom_range(0, 7));
        a   = 64'($urandom_range(0, 320));
      end
      if ($urandom_range(0, 1) != 0) begin
        for (int i = 0; i <= int'(len); i++) begin
          wbuf_d[i] = {$urandom, $urandom}; wbuf_s[i] = 8'($urandom);
        end
        axi_write(4'($urandom), a | hi, len, size, burst, 1'b1);
      end else begin
        axi_read(4'($urandom), a | hi, len, size, burst, 1);
      end
    end

    // Reset mid write burst: accepted beats persist, no B response afterwards.
    send_aw(4'hD, 64'h100, 8'd7, 3'd3, 2'b01);
    for (int i = 0; i < 2; i++) begin
      wdata = 64'h5A5A000000000000 + 64'(i); wstrb = 8'hFF; wvalid = 1'b1;
      model_write(64'h100 + 64'(i) * 64'd8, wdata, 8'hFF);
      @(negedge clk);
    end
    wvalid = 1'b0;
    rst_n  = 1'b0;
    #1;
    reset_outputs_zero("mid_rst");
    repeat (2) @(negedge clk);
    reset_outputs_zero("held_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_bvalid", 64'(bvalid), 64'd0);
    chk("post_rst_wready", 64'(wready), 64'd0);
    chk("post_rst_awready", 64'(awready), 64'd1);
    axi_read(4'hE, 64'h100, 8'd7, 3'd3, 2'b01, 1);
    chk("rst_kept_b0", rd_q[0], 64'h5A5A000000000000);
    axi_read(4'hF, 64'h1000, 8'd0, 3'd3, 2'b01, 0);
    chk("rst_kept_1000", rd_q[0], 64'h1111111111111111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
